// File: rtl/pattern_seq_ctrl_pkg.sv
// Shared types and constants for the pattern sequencer: FSM states, counter width
// and raster total helpers.
package pattern_seq_pkg;

  localparam int unsigned CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sp, input int unsigned bp);
    return act + fp + sp + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sp, input int unsigned bp);
    return act + fp + sp + bp;
  endfunction

endpackage

// File: rtl/pattern_seq_ctrl_raster_cnt.sv
// Horizontal/vertical raster counters with registered de/hs/vs/x/y decode.
// Counters sit at zero whenever run_i is low.
module raster_cnt
  import pattern_seq_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH   = 11,
  parameter int unsigned H_ActivePix  = 1920,
  parameter int unsigned H_FrontPorch = 88,
  parameter int unsigned H_SyncPulse  = 44,
  parameter int unsigned H_BackPorch  = 148,
  parameter int unsigned V_ActivePix  = 1080,
  parameter int unsigned V_FrontPorch = 4,
  parameter int unsigned V_SyncPulse  = 5,
  parameter int unsigned V_BackPorch  = 36
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  run_i,
  output logic                  wrap_o,
  output logic [FIFO_WIDTH-1:0] x_o,
  output logic [FIFO_WIDTH-1:0] y_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o
);

  localparam int unsigned HT = h_total(H_ActivePix, H_FrontPorch, H_SyncPulse, H_BackPorch);
  localparam int unsigned VT = v_total(V_ActivePix, V_FrontPorch, V_SyncPulse, V_BackPorch);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ActivePix);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ActivePix);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ActivePix + H_FrontPorch);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ActivePix + H_FrontPorch + H_SyncPulse);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ActivePix + V_FrontPorch);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ActivePix + V_FrontPorch + V_SyncPulse);

  logic [CNT_W-1:0]      h_q, h_d, v_q, v_d;
  logic [FIFO_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic                  line_end;

  always_comb begin
    line_end = (h_q == H_LAST);
    wrap_o   = run_i && line_end && (v_q == V_LAST);
    h_d      = '0;
    v_d      = '0;
    if (run_i) begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
      end
    end
  end

  // Decode uses the current counter value; the registers below present it one cycle later.
  always_comb begin
    de_d = run_i && (h_q < H_ACT) && (v_q < V_ACT);
    hs_d = run_i && (h_q >= HS_LO) && (h_q < HS_HI);
    vs_d = run_i && (v_q >= VS_LO) && (v_q < VS_HI);
    x_d  = de_d ? FIFO_WIDTH'(h_q) : '0;
    y_d  = de_d ? FIFO_WIDTH'(v_q) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q  <= '0;
      v_q  <= '0;
      x_q  <= '0;
      y_q  <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      x_q  <= x_d;
      y_q  <= y_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign x_o  = x_q;
  assign y_o  = y_q;
  assign de_o = de_q;
  assign hs_o = hs_q;
  assign vs_o = vs_q;

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Frame sequencer for the CSI RX test pattern generator: run/drain FSM, frame-start
// pattern latch (auto-cycle or host-held) and completed-frame counter.
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH         = 11,
  parameter int unsigned H_ActivePix        = 1920,
  parameter int unsigned H_FrontPorch       = 88,
  parameter int unsigned H_SyncPulse        = 44,
  parameter int unsigned H_BackPorch        = 148,
  parameter int unsigned V_ActivePix        = 1080,
  parameter int unsigned V_FrontPorch       = 4,
  parameter int unsigned V_SyncPulse        = 5,
  parameter int unsigned V_BackPorch        = 36,
  parameter int unsigned NUM_PATTERNS       = 8,
  parameter int unsigned FRAMES_PER_PATTERN = 4
) (
  input  logic                  in_pclk,
  input  logic                  in_rst,
  input  logic                  in_enable,
  input  logic                  in_auto,
  input  logic [2:0]            in_pattern,
  output logic [FIFO_WIDTH-1:0] out_x,
  output logic [FIFO_WIDTH-1:0] out_y,
  output logic                  out_valid,
  output logic                  out_de,
  output logic                  out_hs,
  output logic                  out_vs,
  output logic [2:0]            out_pattern,
  output logic [15:0]           out_frame_cnt,
  output logic                  out_busy
);

  localparam logic [2:0]  IDX_LAST = 3'(NUM_PATTERNS - 1);
  localparam logic [15:0] PPF_LAST = 16'(FRAMES_PER_PATTERN - 1);

  state_e      state_q, state_d;
  logic        run, wrap, frame_start;
  logic [2:0]  idx_q, idx_d, pat_q, pat_d, pat_out_q;
  logic [15:0] ppf_q, ppf_d, frame_cnt_q;

  assign run = (state_q != IDLE);

  raster_cnt #(
    .FIFO_WIDTH  (FIFO_WIDTH),
    .H_ActivePix (H_ActivePix),
    .H_FrontPorch(H_FrontPorch),
    .H_SyncPulse (H_SyncPulse),
    .H_BackPorch (H_BackPorch),
    .V_ActivePix (V_ActivePix),
    .V_FrontPorch(V_FrontPorch),
    .V_SyncPulse (V_SyncPulse),
    .V_BackPorch (V_BackPorch)
  ) u_raster (
    .clk_i (in_pclk),
    .rst_i (in_rst),
    .run_i (run),
    .wrap_o(wrap),
    .x_o   (out_x),
    .y_o   (out_y),
    .de_o  (out_de),
    .hs_o  (out_hs),
    .vs_o  (out_vs)
  );

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_enable) begin
          state_d     = RUN;
          frame_start = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (wrap) begin
          state_d     = in_enable ? RUN : IDLE;
          frame_start = in_enable;
        end else begin
          state_d = in_enable ? RUN : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The frame shown uses the index as it stood; the advance prepares the following frame.
  always_comb begin
    idx_d = idx_q;
    ppf_d = ppf_q;
    pat_d = pat_q;
    if (frame_start) begin
      if (!in_auto) begin
        pat_d = in_pattern;
        ppf_d = '0;
      end else begin
        pat_d = idx_q;
        if (ppf_q == PPF_LAST) begin
          ppf_d = '0;
          idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 3'd1;
        end else begin
          ppf_d = ppf_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ppf_q       <= '0;
      pat_q       <= '0;
      pat_out_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ppf_q       <= ppf_d;
      pat_q       <= pat_d;
      pat_out_q   <= pat_q;
      frame_cnt_q <= wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end
  end

  assign out_valid     = out_de;
  assign out_pattern   = pat_out_q;
  assign out_frame_cnt = frame_cnt_q;
  assign out_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Scoreboard bench for pattern_seq_ctrl on a 14x7 raster (8 active pixels, 4 active lines).
module tb_pattern_seq_ctrl;

  localparam int XW = 11;
  localparam int HT = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          auto_m = 1'b1;
  logic [2:0]    pat_in = 3'd0;
  logic [XW-1:0] out_x, out_y;
  logic          out_valid, out_de, out_hs, out_vs, out_busy;
  logic [2:0]    out_pattern;
  logic [15:0]   out_frame_cnt;

  pattern_seq_ctrl #(
    .FIFO_WIDTH        (XW),
    .H_ActivePix       (8),
    .H_FrontPorch      (2),
    .H_SyncPulse       (2),
    .H_BackPorch       (2),
    .V_ActivePix       (4),
    .V_FrontPorch      (1),
    .V_SyncPulse       (1),
    .V_BackPorch       (1),
    .NUM_PATTERNS      (3),
    .FRAMES_PER_PATTERN(2)
  ) dut (
    .in_pclk      (clk),
    .in_rst       (rst),
    .in_enable    (en),
    .in_auto      (auto_m),
    .in_pattern   (pat_in),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_valid    (out_valid),
    .out_de       (out_de),
    .out_hs       (out_hs),
    .out_vs       (out_vs),
    .out_pattern  (out_pattern),
    .out_frame_cnt(out_frame_cnt),
    .out_busy     (out_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] pat;
  } pix_t;

  pix_t sb[$];
  pix_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the active pixels of raster positions 0..last_k with the given pattern.
  task automatic push_frame(input int pat, input int last_k);
    pix_t p;
    for (int k = 0; k <= last_k; k++) begin
      if ((k % HT) < 8 && (k / HT) < 4) begin
        p.x   = 32'(k % HT);
        p.y   = 32'(k / HT);
        p.pat = 32'(pat);
        sb.push_back(p);
      end
    end
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, 32'(out_x), 0);
    chk({tag, "_y"}, 32'(out_y), 0);
    chk({tag, "_de"}, 32'(out_de), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_hs"}, 32'(out_hs), 0);
    chk({tag, "_vs"}, 32'(out_vs), 0);
    chk({tag, "_pattern"}, 32'(out_pattern), 0);
    chk({tag, "_frame_cnt"}, 32'(out_frame_cnt), 0);
    chk({tag, "_busy"}, 32'(out_busy), 0);
  endtask

  // Monitor: every presented pixel is matched against the next expected entry.
  always @(negedge clk) begin
    chk("valid_eq_de", 32'(out_valid), 32'(out_de));
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got pixel x=%0d y=%0d expected none at %0t", out_x, out_y, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("pix_x", 32'(out_x), mon_e.x);
        chk("pix_y", 32'(out_y), mon_e.y);
        chk("pix_pattern", 32'(out_pattern), mon_e.pat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    int h, v;
    nedge(3);
    chk_all_zero("reset");

    // Auto mode, seven back-to-back frames, enable dropped at v=1 of the last one.
    push_frame(0, 97); push_frame(0, 97); push_frame(1, 97); push_frame(1, 97);
    push_frame(2, 97); push_frame(2, 97); push_frame(0, 97);
    rst = 1'b0; en = 1'b1; auto_m = 1'b1;
    nedge(1);
    chk("start_busy", 32'(out_busy), 1);
    chk("start_de", 32'(out_de), 0);
    for (int k = 1; k <= 98; k++) begin
      nedge(1);
      h = (k - 1) % HT;
      v = (k - 1) / HT;
      chk("f1_hs", 32'(out_hs), 32'((h == 10) || (h == 11)));
      chk("f1_vs", 32'(out_vs), 32'(v == 5));
      chk("f1_de", 32'(out_de), 32'((h < 8) && (v < 4)));
    end
    chk("f1_frame_cnt", 32'(out_frame_cnt), 1);
    chk("f1_busy", 32'(out_busy), 1);
    nedge(504);
    chk("f7_start_cnt", 32'(out_frame_cnt), 6);
    en = 1'b0;
    nedge(83);
    chk("drain_cnt", 32'(out_frame_cnt), 6);
    chk("drain_busy", 32'(out_busy), 1);
    nedge(1);
    chk("end_cnt", 32'(out_frame_cnt), 7);
    chk("end_busy", 32'(out_busy), 0);
    nedge(1);
    chk("idle_de", 32'(out_de), 0);
    chk("idle_hs", 32'(out_hs), 0);
    chk("idle_vs", 32'(out_vs), 0);
    chk("idle_x", 32'(out_x), 0);
    chk("idle_y", 32'(out_y), 0);
    chk("auto_sb_empty", 32'(sb.size()), 0);
    nedge(2);
    chk("idle_cnt_hold", 32'(out_frame_cnt), 7);
    chk("idle_busy", 32'(out_busy), 0);

    // Manual mode: pattern 3 then 5 changed mid-frame; enable glitch in the second frame.
    push_frame(3, 97); push_frame(5, 97); push_frame(5, 32);
    auto_m = 1'b0; pat_in = 3'd3; en = 1'b1;
    nedge(33);
    pat_in = 3'd5;
    chk("man_pat_mid", 32'(out_pattern), 3);
    nedge(66);
    chk("man_pat_last", 32'(out_pattern), 3);
    chk("man_cnt_a", 32'(out_frame_cnt), 8);
    nedge(1);
    chk("man_pat_next", 32'(out_pattern), 5);
    chk("man_next_de", 32'(out_de), 1);
    nedge(19);
    en = 1'b0;
    nedge(10);
    chk("glitch_busy", 32'(out_busy), 1);
    en = 1'b1;
    nedge(68);
    chk("glitch_cnt", 32'(out_frame_cnt), 9);
    chk("glitch_busy2", 32'(out_busy), 1);

    // Reset at h=5, v=2 of the third manual frame.
    nedge(33);
    rst = 1'b1;
    nedge(1);
    chk_all_zero("midrst");
    chk("midrst_sb_empty", 32'(sb.size()), 0);

    push_frame(0, 97);
    rst = 1'b0; en = 1'b1; auto_m = 1'b1;
    nedge(1);
    chk("restart_busy", 32'(out_busy), 1);
    nedge(1);
    chk("restart_x", 32'(out_x), 0);
    chk("restart_y", 32'(out_y), 0);
    chk("restart_de", 32'(out_de), 1);
    nedge(49);
    en = 1'b0;
    nedge(48);
    chk("restart_cnt", 32'(out_frame_cnt), 1);
    chk("restart_idle", 32'(out_busy), 0);
    nedge(2);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_seq_ctrl.md
Name: pattern_seq_ctrl

Overview:
- Frame sequencer that drives the pattern-generator datapath on the CSI RX test side.
- Produces raster timing (x, y, valid, de, hs, vs) and a 3-bit pattern select.
- Runs frames on demand and cycles the pattern automatically or holds a host-chosen pattern.
- Pattern changes only at frame boundaries, so the datapath never sees a mid-frame change.

Parameters:
- FIFO_WIDTH, 11: width of out_x/out_y.
- H_ActivePix, 1920: active pixels per line.
- H_FrontPorch, 88: front-porch pixels.
- H_SyncPulse, 44: hsync pixels.
- H_BackPorch, 148: back-porch pixels.
- V_ActivePix, 1080: active lines per frame.
- V_FrontPorch, 4: front-porch lines.
- V_SyncPulse, 5: vsync lines.
- V_BackPorch, 36: back-porch lines.
- NUM_PATTERNS, 8: auto-cycle modulus, 1..8.
- FRAMES_PER_PATTERN, 4: frames per pattern in auto mode, >=1.

Ports:
- in_pclk, input, 1: pixel clock; all logic on rising edge.
- in_rst, input, 1: synchronous active-high reset.
- in_enable, input, 1: level; 1 = run frames, 0 = stop after the current frame.
- in_auto, input, 1: 1 = auto-cycle pattern, 0 = use in_pattern.
- in_pattern, input, 3: manual pattern; sampled at frame start only.
- out_x, output, FIFO_WIDTH: active pixel column; 0 outside active.
- out_y, output, FIFO_WIDTH: active line; 0 outside active.
- out_valid, output, 1: pixel valid; equals out_de.
- out_de, output, 1: data enable.
- out_hs, output, 1: hsync, active high.
- out_vs, output, 1: vsync, active high.
- out_pattern, output, 3: pattern select for the datapath.
- out_frame_cnt, output, 16: completed frames since reset, wraps at 65535->0.
- out_busy, output, 1: 1 while not IDLE.

Behaviour:
- Reset is synchronous and active-high. While in_rst=1 every output is 0, the state is IDLE, and all counters, the pattern index and the per-pattern frame count are 0.
- Totals: H_Total = sum of the H parameters; V_Total = sum of the V parameters. Internal counters are 12 bits.
- States:
  - IDLE: counters held at 0, outputs 0. in_enable=1 sampled -> RUN. On that transition h=0, v=0 and the frame-start pattern latch occurs.
  - RUN: h increments every cycle. At H_Total-1, h wraps to 0 and v increments. At (h,v) = (H_Total-1, V_Total-1), the frame ends.
    - Frame end with in_enable=1: stay in RUN, h=v=0, frame-start latch.
    - Frame end with in_enable=0: go to IDLE.
  - DRAIN: entered from RUN when in_enable falls mid-frame. Counting continues to the frame end, then -> IDLE. in_enable re-asserted during DRAIN -> return to RUN, same frame continues, no restart.
- Raster order per line: active, front porch, sync, back porch. Vertical order is the same.
- Decode:
  - de = (h < H_ActivePix) and (v < V_ActivePix).
  - hs = H_ActivePix+H_FrontPorch <= h < that value + H_SyncPulse.
  - vs uses the same rule on v, for the whole line.
- Outputs are registered. Timing, x and y are valid one cycle after the counter value. out_x = h and out_y = v when de=1, else 0.
- Frame end: out_frame_cnt increments on the cycle the counters wrap from (H_Total-1, V_Total-1), including the final frame before IDLE.
- Frame-start latch:
  - Manual mode (in_auto=0): out_pattern <= in_pattern; per-pattern frame count cleared.
  - Auto mode, per-pattern frame count = FRAMES_PER_PATTERN-1: pattern index advances modulo NUM_PATTERNS and the count clears. Otherwise the count increments.
  - Auto mode drives out_pattern from the index.
  - Switching manual->auto resumes from the current index.
  - out_pattern is registered and aligned with the first pixel of the frame.
- in_pattern or in_auto changes mid-frame have no effect until the next frame start.
- Reset asserted mid-frame: all outputs 0 on the next edge; no partial-frame count.

Decomposition:
- Shared package pattern_seq_pkg holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2;
  - the H/V total localparam functions;
  - the counter width constant 12.
- One sub-module, raster_cnt: h/v counters plus de/hs/vs decode, with ports clock, reset, run, wrap pulse.
- The FSM, pattern latch and frame counter stay in pattern_seq_ctrl.

Test Plan (H=8/2/2/2 giving H_Total=14; V=4/1/1/1 giving V_Total=7; 98 cycles per frame; NUM_PATTERNS=3; FRAMES_PER_PATTERN=2):
- Reset then in_enable=1 -> out_de high for 8 cycles per line on lines 0-3, out_x 0..7. out_hs high at h=10,11. out_vs high for all 14 cycles of line 5. out_busy=1.
- Auto mode, 7 frames -> out_pattern sequence per frame is 0,0,1,1,2,2,0. out_frame_cnt=7 after the 7th wrap.
- Manual mode, in_pattern changed from 3 to 5 at h=4,v=2 -> out_pattern stays 3 until the next frame's first pixel, then 5.
- in_enable dropped at v=1 -> frame completes (last de at v=3), out_frame_cnt+1, IDLE, out_busy=0, all timing outputs 0.
- in_enable dropped then re-raised within the same frame -> no gap, no restart, frame count continues normally.
- in_rst pulsed at v=2,h=5 -> next cycle all outputs 0, out_frame_cnt=0, out_pattern=0. Restart begins at h=0,v=0.
